// File: rtl/int8_outlier_gather_if.sv
// Bundles the two partial-sum input streams and the joined result stream
// of int8_outlier_gather. master = producer/consumer side, slave = gather block.
interface int8_outlier_gather_if #(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = IN_WIDTH + 1,
    parameter int NUM       = 20
);
    logic [NUM-1:0][IN_WIDTH-1:0]  data_in_large;
    logic                          data_in_large_valid;
    logic                          data_in_large_ready;
    logic [NUM-1:0][IN_WIDTH-1:0]  data_in_small;
    logic                          data_in_small_valid;
    logic                          data_in_small_ready;
    logic [NUM-1:0][OUT_WIDTH-1:0] data_out;
    logic                          data_out_valid;
    logic                          data_out_ready;

    modport master (
        output data_in_large, data_in_large_valid, data_in_small, data_in_small_valid,
        output data_out_ready,
        input  data_in_large_ready, data_in_small_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in_large, data_in_large_valid, data_in_small, data_in_small_valid,
        input  data_out_ready,
        output data_in_large_ready, data_in_small_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/int8_outlier_gather.sv
// Recombines the large (outlier) and small (int8) partial-product streams:
// one vector FIFO per branch, an in-order join that pops both heads together,
// an element-wise signed add and a registered output with full backpressure.
// Optional: INT8_OUTLIER_GATHER_SAT_EN selects saturation instead of wrap when
// OUT_WIDTH is narrower than the full-precision sum.
module int8_outlier_gather #(
    parameter int IN_WIDTH   = 36,
    parameter int OUT_WIDTH  = IN_WIDTH + 1,
    parameter int NUM        = 20,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    int8_outlier_gather_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [NUM-1:0][IN_WIDTH-1:0]  vec_t;
    typedef logic [NUM-1:0][OUT_WIDTH-1:0] out_t;

    // branch 0 = large, branch 1 = small
    vec_t       in_vec [2];
    vec_t       head   [2];
    logic [1:0] in_vld;
    logic [1:0] in_rdy;
    logic [1:0] nempty;
    logic       fire;
    logic       out_vld;
    out_t       out_data;
    out_t       sum;

    assign in_vec[0] = bus.data_in_large;
    assign in_vec[1] = bus.data_in_small;
    assign in_vld    = {bus.data_in_small_valid, bus.data_in_large_valid};

    assign bus.data_in_large_ready = in_rdy[0];
    assign bus.data_in_small_ready = in_rdy[1];
    assign bus.data_out            = out_data;
    assign bus.data_out_valid      = out_vld;

    // Join only when both branches hold a vector and the output slot frees up.
    assign fire = nempty[0] && nempty[1] && (!out_vld || bus.data_out_ready);

    for (genvar b = 0; b < 2; b++) begin : g_fifo
        vec_t          mem [FIFO_DEPTH];
        logic [PW-1:0] wptr;
        logic [PW-1:0] rptr;
        logic [CW-1:0] cnt;
        logic          push;

        // Ready comes from the registered count only, so a full FIFO stays
        // closed even in a cycle where the join pops it.
        assign in_rdy[b] = !rst && (cnt < CW'(FIFO_DEPTH));
        assign push      = in_vld[b] && in_rdy[b];
        assign nempty[b] = (cnt != '0);
        assign head[b]   = mem[rptr];

        // Pointers wrap naturally at FIFO_DEPTH (power of two); count tracks occupancy.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (fire) rptr <= rptr + 1'b1;
                cnt <= cnt + CW'(push) - CW'(fire);
            end
        end

        // Vector storage; contents are don't-care until written.
        always_ff @(posedge clk) begin
            if (push) mem[wptr] <= in_vec[b];
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        logic signed [IN_WIDTH:0] s;

        assign s = $signed({head[0][i][IN_WIDTH-1], head[0][i]})
                 + $signed({head[1][i][IN_WIDTH-1], head[1][i]});

        if (OUT_WIDTH >= IN_WIDTH + 1) begin : g_ext
            assign sum[i] = OUT_WIDTH'(s);
        end else begin : g_nrw
`ifdef INT8_OUTLIER_GATHER_SAT_EN
            localparam logic signed [IN_WIDTH:0] SMAX =
                {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
            localparam logic signed [IN_WIDTH:0] SMIN = ~SMAX;
            assign sum[i] = (s > SMAX) ? SMAX[OUT_WIDTH-1:0] :
                            (s < SMIN) ? SMIN[OUT_WIDTH-1:0] : s[OUT_WIDTH-1:0];
`else
            assign sum[i] = s[OUT_WIDTH-1:0];
`endif
        end
    end

    // Output slot: load on join, hold while stalled, empty once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (fire) begin
            out_vld  <= 1'b1;
            out_data <= sum;
        end else if (bus.data_out_ready) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end
    end
endmodule

// File: tb/tb_int8_outlier_gather.sv
// Bench for int8_outlier_gather: directed scenarios plus randomized traffic,
// scored against a queue model of per-branch arrival order and element sums.
// A second narrow instance covers the wrap/saturate behaviour.
module tb_int8_outlier_gather;
    localparam int IW = 36;
    localparam int OW = 37;
    localparam int N  = 20;

    typedef logic [N-1:0][IW-1:0] vec_t;
    typedef logic [N-1:0][63:0]   ev_t;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    int8_outlier_gather_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(N)) bus ();
    int8_outlier_gather_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .NUM(2))   bus8 ();

    int8_outlier_gather #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(N), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int8_outlier_gather #(.IN_WIDTH(8), .OUT_WIDTH(8), .NUM(2), .FIFO_DEPTH(2)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // stimulus state shared between main, driver and monitor
    vec_t pend_l[$], pend_s[$];
    int   rate_l = 100, rate_s = 100;
    bit   ordy_rand = 0;
    bit   ordy_cfg  = 1;
    bit   acc_l, acc_s;
    int   nacc_l = 0, nacc_s = 0;

    // reference model: arrival queues per branch and expected result queue
    vec_t lq[$], sq[$];
    ev_t  eq[$];
    bit   prev_v = 0, prev_r = 0;

    function automatic vec_t fill(input longint v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = IW'(v);
        return r;
    endfunction

    function automatic vec_t one(input longint v0);
        vec_t r = '0;
        r[0] = IW'(v0);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = IW'({$urandom, $urandom});
        return r;
    endfunction

    function automatic ev_t pair_sum(input vec_t a, input vec_t b);
        ev_t r;
        for (int i = 0; i < N; i++)
            r[i] = 64'(longint'($signed(a[i])) + longint'($signed(b[i])));
        return r;
    endfunction

    function automatic longint elem(input int i);
        return longint'($signed(bus.data_out[i]));
    endfunction

    function automatic longint narrow8(input longint s);
`ifdef INT8_OUTLIER_GATHER_SAT_EN
        return (s > 127) ? 127 : (s < -128) ? -128 : s;
`else
        return ((s + 128) % 256 + 256) % 256 - 128;
`endif
    endfunction

    // driver: presents queued vectors, holds each until it is accepted
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc_l) bus.data_in_large_valid = 1'b0;
            if (acc_s) bus.data_in_small_valid = 1'b0;
            if (!bus.data_in_large_valid && pend_l.size() > 0 && $urandom_range(99) < rate_l) begin
                bus.data_in_large = pend_l.pop_front();
                bus.data_in_large_valid = 1'b1;
            end
            if (!bus.data_in_small_valid && pend_s.size() > 0 && $urandom_range(99) < rate_s) begin
                bus.data_in_small = pend_s.pop_front();
                bus.data_in_small_valid = 1'b1;
            end
            bus.data_out_ready = ordy_rand ? 1'($urandom_range(1)) : ordy_cfg;
        end
    end

    // monitor: checks outputs against the model, records upcoming transfers
    initial begin
        forever begin
            @(negedge clk);
            acc_l = 0;
            acc_s = 0;
            if (rst) begin
                lq.delete();
                sq.delete();
                eq.delete();
                prev_v = 0;
                prev_r = 0;
            end else begin
                if (prev_v && !prev_r) check("hold_vld", bus.data_out_valid, 1);
                if (bus.data_out_valid) begin
                    check("out_extra", eq.size() > 0, 1);
                    if (eq.size() > 0) begin
                        for (int i = 0; i < N; i++) check("out_elem", elem(i), $signed(eq[0][i]));
                        if (bus.data_out_ready) void'(eq.pop_front());
                    end
                end
                if (bus.data_in_large_valid && bus.data_in_large_ready) begin
                    lq.push_back(bus.data_in_large);
                    acc_l = 1;
                    nacc_l++;
                end
                if (bus.data_in_small_valid && bus.data_in_small_ready) begin
                    sq.push_back(bus.data_in_small);
                    acc_s = 1;
                    nacc_s++;
                end
                while (lq.size() > 0 && sq.size() > 0)
                    eq.push_back(pair_sum(lq.pop_front(), sq.pop_front()));
                prev_v = bus.data_out_valid;
                prev_r = bus.data_out_ready;
            end
        end
    end

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((pend_l.size() > 0 || pend_s.size() > 0 || eq.size() > 0 || lq.size() > 0 ||
                sq.size() > 0 || bus.data_in_large_valid || bus.data_in_small_valid ||
                bus.data_out_valid) && n < max) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(tag, n < max, 1);
    endtask

    initial begin
        int first, last, cnt, nlow, n, bl, bs;
        bit seen;
        rst = 1'b1;
        bus.data_in_large = '0;
        bus.data_in_small = '0;
        bus.data_in_large_valid = 1'b0;
        bus.data_in_small_valid = 1'b0;
        bus.data_out_ready = 1'b1;
        bus8.data_in_large = '0;
        bus8.data_in_small = '0;
        bus8.data_in_large_valid = 1'b0;
        bus8.data_in_small_valid = 1'b0;
        bus8.data_out_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_rdy_l", bus.data_in_large_ready, 0);
        check("rst_rdy_s", bus.data_in_small_ready, 0);
        check("rst_vld", bus.data_out_valid, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy_l", bus.data_in_large_ready, 1);
        check("post_rst_rdy_s", bus.data_in_small_ready, 1);
        check("post_rst_vld", bus.data_out_valid, 0);
        check("post_rst_dout", bus.data_out == '0, 1);

        // aligned pair, exact latency and single-cycle valid
        pend_l.push_back(one(100));
        pend_s.push_back(one(-3));
        n = 0;
        while (!(bus.data_in_large_valid && bus.data_in_large_ready &&
                 bus.data_in_small_valid && bus.data_in_small_ready) && n < 20) begin
            @(negedge clk); n++;
        end
        check("al_accept", n < 20, 1);
        @(negedge clk);
        check("al_vld_t", bus.data_out_valid, 0);
        @(negedge clk);
        check("al_vld_t1", bus.data_out_valid, 1);
        check("al_e0", elem(0), 97);
        check("al_e1", elem(1), 0);
        @(negedge clk);
        check("al_vld_t2", bus.data_out_valid, 0);
        drain("al_drain", 50);

        // skew: small arrives three cycles after large
        pend_l.push_back(fill(5));
        n = 0;
        while (!(bus.data_in_large_valid && bus.data_in_large_ready) && n < 20) begin
            @(negedge clk); n++;
        end
        check("sk_accept", n < 20, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("sk_novld", bus.data_out_valid, 0);
            check("sk_rdy_l", bus.data_in_large_ready, 1);
            if (k == 2) pend_s.push_back(fill(7));
            if (k == 3) check("sk_s_acc", bus.data_in_small_valid && bus.data_in_small_ready, 1);
        end
        @(negedge clk);
        check("sk_vld", bus.data_out_valid, 1);
        check("sk_e0", elem(0), 12);
        check("sk_e19", elem(N-1), 12);
        drain("sk_drain", 50);

        // backpressure: 6 pushes per branch into a stalled output
        ordy_cfg = 0;
        @(negedge clk);
        bl = nacc_l;
        bs = nacc_s;
        for (int j = 1; j <= 6; j++) begin
            pend_l.push_back(fill(10 * j));
            pend_s.push_back(fill(j));
        end
        repeat (12) @(negedge clk);
        check("bp_acc_l", nacc_l - bl, 5);
        check("bp_acc_s", nacc_s - bs, 5);
        check("bp_rdy_l", bus.data_in_large_ready, 0);
        check("bp_rdy_s", bus.data_in_small_ready, 0);
        check("bp_vld", bus.data_out_valid, 1);
        check("bp_frozen", elem(0), 11);
        ordy_cfg = 1;
        first = -1; last = -1; cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.data_out_valid && bus.data_out_ready) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
                check("bp_order", elem(0), 11 * cnt);
            end
        end
        check("bp_cnt", cnt, 6);
        check("bp_run", last - first + 1, 6);
        drain("bp_drain", 50);

        // reset with two pairs in flight
        ordy_cfg = 0;
        pend_l.push_back(fill(1)); pend_l.push_back(fill(2));
        pend_s.push_back(fill(3)); pend_s.push_back(fill(4));
        repeat (8) @(negedge clk);
        check("mr_vld_before", bus.data_out_valid, 1);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        check("mr_rdy_in_rst", bus.data_in_large_ready, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("mr_vld", bus.data_out_valid, 0);
        check("mr_dout", bus.data_out == '0, 1);
        check("mr_rdy_l", bus.data_in_large_ready, 1);
        check("mr_rdy_s", bus.data_in_small_ready, 1);
        ordy_cfg = 1;
        pend_l.push_back(fill(42));
        pend_s.push_back(fill(1));
        n = 0;
        while (!bus.data_out_valid && n < 20) begin
            @(negedge clk); n++;
        end
        check("mr_fresh_seen", n < 20, 1);
        check("mr_fresh_e0", elem(0), 43);
        drain("mr_drain", 50);

        // streaming: 16 aligned pairs, no stalls
        for (int k = 0; k < 16; k++) begin
            pend_l.push_back(fill(k));
            pend_s.push_back(fill(-2 * k));
        end
        first = -1; last = -1; cnt = 0; nlow = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!bus.data_in_large_ready || !bus.data_in_small_ready) nlow++;
            if (bus.data_out_valid && bus.data_out_ready) begin
                if (first < 0) first = k;
                last = k;
                check("st_val", elem(N-1), -cnt);
                cnt++;
            end
        end
        check("st_rdy_low", nlow, 0);
        check("st_cnt", cnt, 16);
        check("st_run", last - first + 1, 16);
        drain("st_drain", 50);

        // randomized traffic with random skew and backpressure
        for (int r = 0; r < 3; r++) begin
            rate_l = $urandom_range(90, 20);
            rate_s = $urandom_range(90, 20);
            ordy_rand = 1;
            for (int k = 0; k < 40; k++) begin
                pend_l.push_back(rand_vec());
                pend_s.push_back(rand_vec());
            end
            drain("rnd_drain", 3000);
            ordy_rand = 0;
            rate_l = 100;
            rate_s = 100;
        end

        // narrow instance: wrap or saturate
        @(posedge clk); #2;
        bus8.data_in_large[0] = 8'd127;
        bus8.data_in_large[1] = 8'h80;
        bus8.data_in_small[0] = 8'd5;
        bus8.data_in_small[1] = 8'hFF;
        bus8.data_in_large_valid = 1'b1;
        bus8.data_in_small_valid = 1'b1;
        @(negedge clk);
        check("ov_rdy", bus8.data_in_large_ready && bus8.data_in_small_ready, 1);
        @(posedge clk); #2;
        bus8.data_in_large_valid = 1'b0;
        bus8.data_in_small_valid = 1'b0;
        @(negedge clk);
        seen = bus8.data_out_valid;
        check("ov_early", seen, 0);
        @(negedge clk);
        check("ov_vld", bus8.data_out_valid, 1);
        check("ov_e0", longint'($signed(bus8.data_out[0])), narrow8(127 + 5));
        check("ov_e1", longint'($signed(bus8.data_out[1])), narrow8(-128 - 1));
        @(negedge clk);
        check("ov_clr", bus8.data_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
